// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first,
//   with a registered carry between bit slices.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a, b   in   [WIDTH-1:0] operands, captured on the accepting edge
//   ci     in   carry-in, captured on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, s/co just updated
//   s      out  [WIDTH-1:0] sum of the last completed addition
//   co     out  carry-out of the last completed addition
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_s, fa_c;
    logic             last_bit;
    logic [WIDTH-1:0] sum_nxt;

    // The single full-adder cell
    assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry_q;
    assign fa_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; busy/done are registered decodes of the next state so
    // no output has a combinational path from anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == SHIFT);
            done    <= (state_d == DONE);
        end
    end

    // Partial-sum shift register. New bits enter at the MSB; the bit that
    // would fall out of the LSB is never needed, so only WIDTH-1 bits are
    // stored and the final sum is {current bit, stored bits}.
    generate
        if (WIDTH == 1) begin : g_sum1
            assign sum_nxt = fa_s;
        end else begin : g_sumn
            logic [WIDTH-2:0] sum_sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    sum_sr <= '0;
                else if (state_q == IDLE && start)
                    sum_sr <= '0;
                else if (state_q == SHIFT)
                    sum_sr <= sum_nxt[WIDTH-1:1];
            end
            assign sum_nxt = {fa_s, sum_sr};
        end
    endgenerate

    // Operand/carry/counter datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s       <= '0;
            co      <= 1'b0;
        end else if (state_q == IDLE && start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= ci;
            cnt_q   <= '0;
        end else if (state_q == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry_q <= fa_c;
            cnt_q   <= cnt_q + 1'b1;
            // s/co only move on the final bit so they hold the previous
            // result for the whole operation.
            if (last_bit) begin
                s  <= sum_nxt;
                co <= fa_c;
            end
        end
    end

endmodule
